// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU widths, fetch state encoding and vector defaults
package cpu_pkg;

  localparam int PC_W    = 16;
  localparam int INSTR_W = 32;

  // Also used by the execute stage's interrupt logic.
  localparam logic [PC_W-1:0] RESET_PC_DEF = 16'h0000;
  localparam logic [PC_W-1:0] INT_VEC_DEF  = 16'h0010;

  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_skid.sv
// rtl/fetch_skid.sv - one-entry {pc, instr} holding buffer; flush beats push
module fetch_skid #(
  parameter int PC_W    = cpu_pkg::PC_W,
  parameter int INSTR_W = cpu_pkg::INSTR_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic               flush_i,
  input  logic [PC_W-1:0]    pc_i,
  input  logic [INSTR_W-1:0] instr_i,
  output logic               full_o,
  output logic [PC_W-1:0]    pc_o,
  output logic [INSTR_W-1:0] instr_o
);

  logic               full_q, full_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;

  // A simultaneous pop and push replaces the entry and leaves it full.
  always_comb begin
    full_d  = full_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (flush_i) begin
      full_d = 1'b0;
    end else if (push_i) begin
      full_d  = 1'b1;
      pc_d    = pc_i;
      instr_d = instr_i;
    end else if (pop_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      full_q  <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      full_q  <= full_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign full_o  = full_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC generation, instruction fetch handshake and decode output register
module fetch_stage #(
  parameter int                  PC_W     = cpu_pkg::PC_W,
  parameter int                  INSTR_W  = cpu_pkg::INSTR_W,
  parameter logic [PC_W-1:0]     RESET_PC = cpu_pkg::RESET_PC_DEF,
  parameter logic [PC_W-1:0]     INT_VEC  = cpu_pkg::INT_VEC_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_addr,
  input  logic               int_req,
  output logic               int_ack,
  input  logic               stall,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  output logic [PC_W-1:0]    if_pc,
  output logic [INSTR_W-1:0] if_instr
);
  import cpu_pkg::*;

  fetch_state_t       state_q, state_d;
  logic [PC_W-1:0]    fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]    imem_addr_q, imem_addr_d;
  logic               imem_req_q, imem_req_d;
  logic               if_valid_q, if_valid_d;
  logic [PC_W-1:0]    if_pc_q, if_pc_d;
  logic [INSTR_W-1:0] if_instr_q, if_instr_d;
  logic               int_ack_q, int_ack_d;

  logic               skid_push, skid_pop, skid_flush, skid_full;
  logic [PC_W-1:0]    skid_pc;
  logic [INSTR_W-1:0] skid_instr;

  logic int_take, redirect, fetched, consume, out_free;

  // A branch defers the interrupt; int_ack_q blocks a second take before int_req drops.
  assign int_take = int_req && !branch_taken && !int_ack_q;
  assign redirect = branch_taken || int_take;
  assign fetched  = (state_q == WAIT) && imem_ack && !redirect;
  assign consume  = if_valid_q && !stall;
  assign out_free = !if_valid_q || !stall;

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    imem_req_d  = imem_req_q;
    imem_addr_d = imem_addr_q;
    if_valid_d  = if_valid_q;
    if_pc_d     = if_pc_q;
    if_instr_d  = if_instr_q;
    int_ack_d   = 1'b0;
    skid_push   = 1'b0;
    skid_pop    = 1'b0;
    skid_flush  = 1'b0;

    if ((state_q != ISSUE) && imem_ack) begin
      imem_req_d = 1'b0;
    end

    if (redirect) begin
      fetch_pc_d = branch_taken ? branch_addr : INT_VEC;
      int_ack_d  = int_take;
      if_valid_d = 1'b0;
      skid_flush = 1'b1;
      state_d    = ((state_q != ISSUE) && !imem_ack) ? DRAIN : ISSUE;
    end else begin
      case (state_q)
        ISSUE: begin
          if (!skid_full) begin
            imem_req_d  = 1'b1;
            imem_addr_d = fetch_pc_q;
            state_d     = WAIT;
          end
        end
        WAIT: begin
          if (imem_ack) begin
            fetch_pc_d = fetch_pc_q + 1'b1;
            state_d    = ISSUE;
          end
        end
        DRAIN: begin
          if (imem_ack) begin
            state_d = ISSUE;
          end
        end
        default: state_d = ISSUE;
      endcase

      if (consume && skid_full) begin
        if_pc_d    = skid_pc;
        if_instr_d = skid_instr;
        if_valid_d = 1'b1;
        skid_pop   = 1'b1;
        skid_push  = fetched;
      end else if (fetched && out_free) begin
        if_pc_d    = imem_addr_q;
        if_instr_d = imem_rdata;
        if_valid_d = 1'b1;
      end else if (fetched) begin
        skid_push = 1'b1;
      end else if (consume) begin
        if_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ISSUE;
      fetch_pc_q  <= RESET_PC;
      imem_req_q  <= 1'b0;
      imem_addr_q <= '0;
      if_valid_q  <= 1'b0;
      if_pc_q     <= '0;
      if_instr_q  <= '0;
      int_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      imem_req_q  <= imem_req_d;
      imem_addr_q <= imem_addr_d;
      if_valid_q  <= if_valid_d;
      if_pc_q     <= if_pc_d;
      if_instr_q  <= if_instr_d;
      int_ack_q   <= int_ack_d;
    end
  end

  fetch_skid #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_skid (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (skid_push),
    .pop_i   (skid_pop),
    .flush_i (skid_flush),
    .pc_i    (imem_addr_q),
    .instr_i (imem_rdata),
    .full_o  (skid_full),
    .pc_o    (skid_pc),
    .instr_o (skid_instr)
  );

  assign imem_req  = imem_req_q;
  assign imem_addr = imem_addr_q;
  assign if_valid  = if_valid_q;
  assign if_pc     = if_pc_q;
  assign if_instr  = if_instr_q;
  assign int_ack   = int_ack_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - fetch_stage bench: queue-based reference model, latency-programmable memory, directed tests
module tb_fetch_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst, branch_taken, int_req, stall, imem_ack;
  logic [15:0] branch_addr;
  logic [31:0] imem_rdata;
  logic        int_ack, imem_req, if_valid;
  logic [15:0] imem_addr, if_pc;
  logic [31:0] if_instr;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk          (clk),
    .rst          (rst),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .int_req      (int_req),
    .int_ack      (int_ack),
    .stall        (stall),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .if_valid     (if_valid),
    .if_pc        (if_pc),
    .if_instr     (if_instr)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // memory model state and observation logs
  int          lat = 1;
  logic        mem_busy;
  int          mem_cnt;
  logic [15:0] mem_addr;
  logic [15:0] issued[$];
  logic [47:0] delivered[$];

  // reference model: pending instructions visible to decode form a queue (front = output)
  logic        live = 1'b0;
  logic [15:0] m_pc, m_addr;
  logic        m_busy, m_discard, m_int_ack;
  logic [47:0] m_out[$];
  logic        take_int, room, ack_seen;

  logic        s_rst, s_br, s_irq, s_stall, s_ack, s_valid;
  logic [15:0] s_ba, s_pc;
  logic [31:0] s_rdata, s_instr;

  initial begin
    imem_ack = 1'b0; imem_rdata = '0; mem_busy = 1'b0; mem_cnt = 0; mem_addr = '0;
    forever begin
      @(posedge clk);
      s_rst = rst; s_br = branch_taken; s_ba = branch_addr; s_irq = int_req;
      s_stall = stall; s_ack = imem_ack; s_rdata = imem_rdata;
      s_valid = if_valid; s_pc = if_pc; s_instr = if_instr;
      #1;
      if (s_rst) begin
        mem_busy = 1'b0;
        imem_ack = 1'b0;
      end else begin
        if (s_ack) begin
          imem_ack = 1'b0;
          mem_busy = 1'b0;
        end
        if (!mem_busy && imem_req === 1'b1) begin
          mem_busy = 1'b1;
          mem_cnt  = 0;
          mem_addr = imem_addr;
          issued.push_back(imem_addr);
        end
        if (mem_busy && !imem_ack) begin
          mem_cnt++;
          if (mem_cnt >= lat) begin
            imem_ack   = 1'b1;
            imem_rdata = 32'hA000 + {16'h0000, mem_addr};
          end
        end
      end

      if (s_rst) begin
        live = 1'b1; m_pc = RESET_PC_DEF; m_addr = '0; m_busy = 1'b0;
        m_discard = 1'b0; m_int_ack = 1'b0; m_out.delete();
      end else if (live) begin
        take_int  = s_irq && !s_br && !m_int_ack;
        room      = m_out.size() < 2;
        ack_seen  = m_busy && s_ack;
        m_int_ack = take_int;
        if (s_br || take_int) begin
          m_out.delete();
          m_pc = s_br ? s_ba : INT_VEC_DEF;
          if (ack_seen) begin
            m_busy = 1'b0; m_discard = 1'b0;
          end else if (m_busy) begin
            m_discard = 1'b1;
          end
        end else begin
          if (s_valid && !s_stall) delivered.push_back({s_pc, s_instr});
          if (m_out.size() > 0 && !s_stall) void'(m_out.pop_front());
          if (ack_seen) begin
            m_busy = 1'b0;
            if (!m_discard) begin
              m_out.push_back({m_addr, s_rdata});
              m_pc = m_pc + 16'd1;
            end
            m_discard = 1'b0;
          end else if (!m_busy && room) begin
            m_busy = 1'b1;
            m_addr = m_pc;
          end
        end
      end

      if (live) begin
        chk("model imem_req", imem_req, m_busy);
        chk("model imem_addr", imem_addr, m_addr);
        chk("model if_valid", if_valid, m_out.size() > 0);
        chk("model int_ack", int_ack, m_int_ack);
        if (m_out.size() > 0) begin
          chk("model if_pc", if_pc, m_out[0][47:32]);
          chk("model if_instr", if_instr, m_out[0][31:0]);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #3;
  endtask

  task automatic chk_deliv(input string name, input int idx, input logic [15:0] pc, input logic [31:0] ins);
    chk(name, (idx < delivered.size()) ? {16'h0, delivered[idx]} : 64'hDEAD_DEAD_DEAD_DEAD, {16'h0, pc, ins});
  endtask

  task automatic chk_issue(input string name, input int idx, input logic [15:0] addr);
    chk(name, (idx < issued.size()) ? {48'h0, issued[idx]} : 64'hDEAD_DEAD_DEAD_DEAD, {48'h0, addr});
  endtask

  task automatic wait_addr(input string name, input logic [15:0] addr, input int max);
    int k = 0;
    while (!(imem_req === 1'b1 && imem_addr === addr) && k < max) begin
      cyc();
      k++;
    end
    chk(name, k < max, 1'b1);
  endtask

  initial begin
    int k;
    int bad;
    rst = 1'b1; branch_taken = 1'b0; branch_addr = '0; int_req = 1'b0; stall = 1'b0;
    cyc(); cyc();
    chk("rst_req", imem_req, 1'b0);
    chk("rst_valid", if_valid, 1'b0);
    chk("rst_addr", imem_addr, 16'h0000);
    chk("rst_int_ack", int_ack, 1'b0);

    // sequential fetch at 1-cycle latency
    rst = 1'b0; issued.delete(); delivered.delete();
    repeat (8) cyc();
    for (int i = 0; i < 4; i++) chk_issue("t1_addr", i, 16'(i));
    for (int i = 0; i < 3; i++) chk_deliv("t1_deliv", i, 16'(i), 32'hA000 + 32'(i));

    // stall: output holds, skid fills, then drains in order
    chk("t2_pc_before", if_pc, 16'd3);
    stall = 1'b1;
    repeat (5) begin
      cyc();
      chk("t2_hold_pc", if_pc, 16'd3);
      chk("t2_hold_valid", if_valid, 1'b1);
    end
    chk("t2_req_idle", imem_req, 1'b0);
    delivered.delete();
    stall = 1'b0;
    cyc();
    chk("t2_skid_out", {if_pc, if_instr}, {16'd4, 32'hA004});
    repeat (8) cyc();
    for (int i = 0; i < 4; i++) chk_deliv("t2_order", i, 16'(3 + i), 32'hA003 + 32'(i));

    // branch during a 3-cycle fetch of address 5
    lat = 3; rst = 1'b1; cyc(); rst = 1'b0;
    wait_addr("t3_wait5", 16'd5, 200);
    branch_taken = 1'b1; branch_addr = 16'h0040;
    delivered.delete(); issued.delete();
    cyc();
    branch_taken = 1'b0;
    repeat (2) begin
      chk("t3_addr_hold", imem_addr, 16'd5);
      chk("t3_req_hold", imem_req, 1'b1);
      cyc();
    end
    repeat (15) cyc();
    chk_issue("t3_redirect_addr", 0, 16'h0040);
    chk_deliv("t3_first", 0, 16'h0040, 32'hA040);
    bad = 0;
    foreach (delivered[i]) if (delivered[i][47:32] == 16'd5) bad++;
    chk("t3_no_instr5", bad, 0);

    // branch and interrupt together: interrupt deferred one cycle
    lat = 1;
    repeat (3) cyc();
    issued.delete(); delivered.delete();
    branch_taken = 1'b1; branch_addr = 16'h0080; int_req = 1'b1;
    cyc();
    branch_taken = 1'b0;
    chk("t4_ack_defer", int_ack, 1'b0);
    cyc();
    chk("t4_ack_pulse", int_ack, 1'b1);
    int_req = 1'b0;
    cyc();
    chk("t4_ack_low", int_ack, 1'b0);
    repeat (6) cyc();
    chk_issue("t4_vec", 0, 16'h0010);
    chk_deliv("t4_first", 0, 16'h0010, 32'hA010);

    // PC wrap
    delivered.delete();
    branch_taken = 1'b1; branch_addr = 16'hFFFF;
    cyc();
    branch_taken = 1'b0;
    repeat (8) cyc();
    chk_deliv("t5_ffff", 0, 16'hFFFF, 32'h0001_9FFF);
    chk_deliv("t5_0000", 1, 16'h0000, 32'h0000_A000);

    // reset with an ack pending
    lat = 3;
    k = 0;
    while (!(imem_req === 1'b1 && imem_ack === 1'b0) && k < 50) begin
      cyc();
      k++;
    end
    chk("t6_wait_req", k < 50, 1'b1);
    rst = 1'b1;
    cyc();
    chk("t6_req", imem_req, 1'b0);
    chk("t6_addr", imem_addr, 16'h0000);
    chk("t6_valid", if_valid, 1'b0);
    chk("t6_pc", if_pc, 16'h0000);
    chk("t6_instr", if_instr, 32'h0);
    chk("t6_int_ack", int_ack, 1'b0);
    rst = 1'b0; issued.delete(); delivered.delete();
    repeat (10) cyc();
    chk_issue("t6_first_addr", 0, RESET_PC_DEF);
    chk_deliv("t6_first_instr", 0, 16'h0000, 32'hA000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Front end of the CPU pipeline. Generates the PC, fetches instructions from instruction memory over a req/ack handshake, and presents {pc, instr, valid} to decode. It consumes the redirect interface driven by the execute stage (branch_taken/branch_addr) and the interrupt-entry request. A one-entry skid buffer absorbs a returning fetch while decode is stalled.

Parameters:
PC_W, 16, PC and instruction-memory address width
INSTR_W, 32, instruction word width
RESET_PC, 16'h0000, first fetch address after reset
INT_VEC, 16'h0010, interrupt handler entry address

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, synchronous, active-high
branch_taken  in  1  redirect pulse from execute stage, valid one cycle
branch_addr  in  PC_W  redirect target, sampled when branch_taken=1
int_req  in  1  interrupt entry request, level, held until int_ack
int_ack  out  1  one-cycle pulse: interrupt redirect accepted
stall  in  1  decode cannot accept; if_* must hold
imem_req  out  1  fetch request
imem_addr  out  PC_W  fetch address, stable while imem_req=1 and not acked
imem_ack  in  1  read data valid; earliest one cycle after imem_req rises
imem_rdata  in  INSTR_W  instruction word, valid with imem_ack
if_valid  out  1  if_pc/if_instr hold a live instruction
if_pc  out  PC_W  PC of if_instr
if_instr  out  INSTR_W  fetched instruction

Behaviour:
- Reset (rst=1 at an edge): fetch_pc=RESET_PC, state=ISSUE, imem_req=0, imem_addr=0, if_valid=0, if_pc=0, if_instr=0, int_ack=0, skid empty. Reset wins over every other input, including an outstanding request, which is abandoned. The memory must also be reset.
- States: ISSUE, WAIT, DRAIN.
  - ISSUE: if skid empty, raise imem_req with imem_addr=fetch_pc, then go to WAIT. If skid full, stay in ISSUE with imem_req=0.
  - WAIT: hold imem_req and imem_addr until imem_ack. On ack: imem_req=0 and fetch_pc=fetch_pc+1, wrapping mod 2^PC_W (16'hFFFF -> 16'h0000).
    - Output free (if_valid=0 or stall=0): load if_pc/if_instr, set if_valid=1.
    - Output blocked: write the data to the skid.
    - Next state is ISSUE, so there is one request every two cycles at 1-cycle memory latency.
  - DRAIN: a redirect arrived while a request was outstanding. Keep imem_req/imem_addr until ack, discard the data, then go to ISSUE with fetch_pc as set by the redirect.
- Output register: when stall=0 and if_valid=1, the instruction is consumed. If the skid is full, the skid moves to the output register and the skid empties. Otherwise if_valid=0 unless a new ack loads the register in the same cycle.
- Redirect sources: branch_taken has priority over int_req.
  - branch_taken=1: fetch_pc=branch_addr next cycle. Flush if_valid=0 and the skid, ignoring stall. If WAIT with no ack this cycle, go to DRAIN; otherwise go to ISSUE. Data acked in the same cycle as branch_taken is discarded.
  - int_req=1 and branch_taken=0: same action with target INT_VEC. int_ack=1 for exactly one cycle.
  - int_req with branch_taken: the interrupt is deferred. int_ack stays 0, and int_req, still held, is taken on the next cycle without branch_taken.
  - Redirect in DRAIN: retarget fetch_pc and stay in DRAIN.
- Latency:
  - Redirect at edge N -> imem_addr=target with imem_req=1 at edge N+1 if no request was outstanding; otherwise one cycle after the drained ack.
  - Ack at edge N -> if_valid=1 from edge N (registered on that edge) if the output was free.
- Invariant: at most one outstanding request. An instruction is never duplicated or dropped, except by flush.

Decomposition:
- Shared package cpu_pkg:
  - PC_W and INSTR_W constants.
  - fetch_state_t enum {ISSUE, WAIT, DRAIN}.
  - RESET_PC/INT_VEC defaults, shared with the execute stage's interrupt logic.
- Sub-module fetch_skid: one-entry {pc, instr} buffer with push, pop, flush, full. Flush has priority over push.

Test Plan:
- Reset, then 1-cycle-latency memory returning instr=pc+32'hA000, stall=0 -> imem_addr 0,1,2,3 on alternate cycles; decode sees (0,A000),(1,A001),(2,A002) in order, if_valid gaps of one cycle.
- stall=1 held 5 cycles with if_valid=1 -> if_* constant. The next ack fills the skid and imem_req stays 0. On stall release, the skid instr appears on the following cycle, then fetch resumes with no loss or duplicate.
- Memory latency 3, branch_taken=1 with branch_addr=16'h0040 one cycle after req for addr 5:
  - imem_addr stays 5 until ack, then DRAIN.
  - Instr 5 never reaches if_valid.
  - Next request has addr 16'h0040.
- branch_taken (addr 16'h0080) and int_req in the same cycle -> fetch goes to 16'h0080 with int_ack=0. Next cycle int_ack=1, then fetch goes to 16'h0010.
- Branch to 16'hFFFF -> fetches FFFF then 0000; if_pc shows FFFF then 0000.
- rst asserted during WAIT with ack pending -> all outputs reset next cycle; a later stale ack is ignored (memory reset too); first request addr=RESET_PC.
